// File: rtl/line_sched_pkg.sv
// line_sched_pkg: shared types and constants for the line scheduler.
//   state_t    scheduler FSM states
//   segment_t  one line segment {x0, y0, x1, y1}, 64 bits
//   COORD_W    coordinate width in pixels
//   RELEASE_CYCLES  cycles drw_start is held low after each segment
package line_sched_pkg;

  localparam int COORD_W        = 16;
  localparam int SEG_W          = 4 * COORD_W;
  localparam int RELEASE_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    WAIT_BUSY,
    WAIT_DONE,
    RELEASE
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
  } segment_t;

  // A segment whose endpoints coincide never completes in the drawer.
  function automatic logic is_point(segment_t s);
    return (s.x0 == s.x1) && (s.y0 == s.y1);
  endfunction

endpackage

// File: rtl/seg_fifo.sv
// seg_fifo: synchronous segment FIFO, SEG_W bits x DEPTH entries.
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        empties the FIFO in one cycle; wins over push
//   push, din    write port (ignored when full)
//   pop, dout    read port; dout shows the head combinationally
//   full, empty  status
//   level        number of stored entries
module seg_fifo
  import line_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  segment_t               din,
  input  logic                   pop,
  output segment_t               dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  segment_t        mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            wr_en;
  logic            rd_en;

  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty;

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/line_scheduler.sv
// line_scheduler: feeds queued line segments to the wireframe drawer one at a
// time, generating a re-armed start level and dropping degenerate or hung lines.
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        segment push handshake, cmd_x0..cmd_y1 endpoints
//   flush                      discard all queued (not in-flight) segments
//   drw_x0..drw_y1, drw_start  registered segment and start level to drawer
//   drw_busy                   drawer running a line
//   idle                       FIFO empty and FSM idle (registered)
//   fifo_level                 queued segment count
//   lines_done                 completed or dropped segments, wrapping
//   timeout_err                sticky watchdog flag, cleared by reset only
module line_scheduler
  import line_sched_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BUSY_WAIT = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [COORD_W-1:0]     cmd_x0,
  input  logic [COORD_W-1:0]     cmd_y0,
  input  logic [COORD_W-1:0]     cmd_x1,
  input  logic [COORD_W-1:0]     cmd_y1,
  input  logic                   flush,
  output logic [COORD_W-1:0]     drw_x0,
  output logic [COORD_W-1:0]     drw_y0,
  output logic [COORD_W-1:0]     drw_x1,
  output logic [COORD_W-1:0]     drw_y1,
  output logic                   drw_start,
  input  logic                   drw_busy,
  output logic                   idle,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            lines_done,
  output logic                   timeout_err
);

  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (TIMEOUT > BUSY_WAIT) ? TIMEOUT : BUSY_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             start_next;
  logic             pop;
  logic             load;
  logic             done_inc;
  logic             to_set;
  logic             push;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level_next;
  segment_t         cmd_seg;
  segment_t         head;
  segment_t         seg_q;

  // No bypass: a pop in the same cycle does not open a slot for a full FIFO.
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign cmd_seg   = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1};

  seg_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (cmd_seg),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Occupancy after this edge, used so idle can be registered without lag.
  assign level_next = flush ? '0 : (fifo_level + LW'(push) - LW'(pop));

  // One counter serves the busy-rise watchdog, the busy-high watchdog and the
  // release hold, since those phases never overlap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    load       = 1'b0;
    done_inc   = 1'b0;
    to_set     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_next = LOAD;
      end
      LOAD: begin
        cnt_next = '0;
        // A flush in the preceding cycle can leave nothing to pop.
        if (empty) begin
          state_next = IDLE;
        end else begin
          pop  = 1'b1;
          load = 1'b1;
          if (is_point(head)) begin
            done_inc   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = ARM;
          end
        end
      end
      ARM: begin
        // The ARM cycle already counts toward the busy-rise window.
        cnt_next   = CNT_W'(1);
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (drw_busy) begin
          cnt_next   = '0;
          state_next = WAIT_DONE;
        end else if (cnt >= CNT_W'(BUSY_WAIT - 1)) begin
          to_set     = 1'b1;
          cnt_next   = '0;
          state_next = RELEASE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!drw_busy) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end else if (cnt >= CNT_W'(TIMEOUT - 1)) begin
          to_set     = 1'b1;
          cnt_next   = '0;
          state_next = RELEASE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt >= CNT_W'(RELEASE_CYCLES - 1)) begin
          done_inc   = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
    start_next = (state_next == ARM) || (state_next == WAIT_BUSY) ||
                 (state_next == WAIT_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      drw_start   <= 1'b0;
      seg_q       <= '0;
      lines_done  <= '0;
      timeout_err <= 1'b0;
      idle        <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      drw_start <= start_next;
      idle      <= (state_next == IDLE) && (level_next == '0);
      if (load)     seg_q       <= head;
      if (done_inc) lines_done  <= lines_done + 16'd1;
      if (to_set)   timeout_err <= 1'b1;
    end
  end

  assign drw_x0 = seg_q.x0;
  assign drw_y0 = seg_q.y0;
  assign drw_x1 = seg_q.x1;
  assign drw_y1 = seg_q.y1;

endmodule

// File: tb/tb_line_scheduler.sv
module tb_line_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic        flush = 1'b0;
  logic [15:0] drw_x0, drw_y0, drw_x1, drw_y1;
  logic        drw_start;
  logic        drw_busy;
  logic        idle;
  logic [4:0]  fifo_level;
  logic [15:0] lines_done;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  line_scheduler #(.DEPTH(16), .BUSY_WAIT(16), .TIMEOUT(65535)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .flush(flush), .drw_x0(drw_x0), .drw_y0(drw_y0), .drw_x1(drw_x1),
    .drw_y1(drw_y1), .drw_start(drw_start), .drw_busy(drw_busy), .idle(idle),
    .fifo_level(fifo_level), .lines_done(lines_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Drawer model and output monitor, both evaluated on the falling edge.
  logic        model_busy = 1'b0;
  logic        dm_hold = 1'b0;
  logic        dm_en = 1'b1;
  int          dm_delay = 2;
  int          dm_len = 11;
  int          dm_phase = 0;
  int          dm_cnt = 0;
  logic        start_prev = 1'b0;
  int          rises = 0;
  int          low_run = 0;
  int          gap_viol = 0;
  int          stab_viol = 0;
  logic [63:0] cap = '0;
  logic [63:0] rec[$];

  assign drw_busy = model_busy | dm_hold;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_busy = 1'b0; dm_phase = 0; start_prev = 1'b0;
      rises = 0; low_run = 0; gap_viol = 0; stab_viol = 0; rec.delete();
    end else begin
      if (drw_start && !start_prev && dm_en) begin
        dm_phase = 1; dm_cnt = dm_delay;
      end else if (dm_phase == 1) begin
        if (dm_cnt <= 1) begin model_busy = 1'b1; dm_phase = 2; dm_cnt = dm_len; end
        else dm_cnt = dm_cnt - 1;
      end else if (dm_phase == 2) begin
        if (dm_cnt <= 1) begin model_busy = 1'b0; dm_phase = 0; end
        else dm_cnt = dm_cnt - 1;
      end
      if (drw_start && !start_prev) begin
        rises = rises + 1;
        if (rises > 1 && low_run < 2) gap_viol = gap_viol + 1;
        cap = {drw_x0, drw_y0, drw_x1, drw_y1};
        rec.push_back(cap);
      end else if (drw_start && start_prev && ({drw_x0, drw_y0, drw_x1, drw_y1} != cap)) begin
        stab_viol = stab_viol + 1;
      end
      if (drw_start) low_run = 0; else low_run = low_run + 1;
      start_prev = drw_start;
    end
  end

  function automatic logic [63:0] seg(int i);
    logic [15:0] a, b, c, d;
    a = 16'(i * 3 + 1); b = 16'(i * 5 + 2); c = 16'(i * 7 + 300); d = 16'(i + 900);
    return {a, b, c, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; flush = 1'b0;
    dm_hold = 1'b0; dm_en = 1'b1; dm_delay = 2; dm_len = 11;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Offers one segment and returns just after the handshake edge.
  task automatic push(input logic [63:0] s);
    int n;
    n = 0;
    {cmd_x0, cmd_y0, cmd_x1, cmd_y1} = s;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin tick(); n++; end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL push_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start_fall(output int n);
    n = 0;
    while (drw_start === 1'b1 && n < 1000) begin tick(); n++; end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < limit) begin tick(); n++; end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
    checks++; if (drw_start !== 1'b0) begin errors++; $display("FAIL reset_drw_start: got %0b want 0", drw_start); end
    checks++; if ({drw_x0, drw_y0, drw_x1, drw_y1} !== 64'd0) begin errors++; $display("FAIL reset_coords: got %h want 0", {drw_x0, drw_y0, drw_x1, drw_y1}); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b want 1", idle); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (lines_done !== 16'd0) begin errors++; $display("FAIL reset_lines_done: got %0d want 0", lines_done); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %0b want 0", timeout_err); end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    push({16'd10, 16'd10, 16'd20, 16'd15});
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL single_level_n: got %0d want 1", fifo_level); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_low: got %0b want 0", idle); end
    tick();
    checks++; if (drw_start !== 1'b0) begin errors++; $display("FAIL single_start_n1: got %0b want 0", drw_start); end
    tick();
    checks++; if (drw_start !== 1'b1) begin errors++; $display("FAIL single_start_n2: got %0b want 1", drw_start); end
    checks++; if ({drw_x0, drw_y0, drw_x1, drw_y1} !== {16'd10, 16'd10, 16'd20, 16'd15}) begin
      errors++; $display("FAIL single_coords: got %h want %h", {drw_x0, drw_y0, drw_x1, drw_y1}, {16'd10, 16'd10, 16'd20, 16'd15}); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL single_level_pop: got %0d want 0", fifo_level); end
    wait_start_fall(n);
    checks++; if (n !== 14) begin errors++; $display("FAIL single_start_cycles: got %0d want 14", n); end
    tick();
    checks++; if (lines_done !== 16'd0 || idle !== 1'b0) begin errors++; $display("FAIL single_release_hold: lines_done=%0d idle=%0b want 0 0", lines_done, idle); end
    tick();
    checks++; if (lines_done !== 16'd1) begin errors++; $display("FAIL single_lines_done: got %0d want 1", lines_done); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %0b want 1", idle); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL single_coord_stable: got %0d changes want 0", stab_viol); end
  endtask

  task automatic test_zero_length();
    do_reset();
    push({16'd5, 16'd5, 16'd5, 16'd5});
    tick(); tick();
    checks++; if (lines_done !== 16'd1) begin errors++; $display("FAIL zero_lines_done: got %0d want 1", lines_done); end
    checks++; if (drw_start !== 1'b0) begin errors++; $display("FAIL zero_start: got %0b want 0", drw_start); end
    checks++; if (drw_x0 !== 16'd5) begin errors++; $display("FAIL zero_loaded: got %0d want 5", drw_x0); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL zero_idle: got %0b want 1", idle); end
    repeat (3) tick();
    checks++; if (rises !== 0) begin errors++; $display("FAIL zero_no_start: got %0d rises want 0", rises); end
    push(seg(80));
    tick(); tick();
    checks++; if (drw_start !== 1'b1 || {drw_x0, drw_y0, drw_x1, drw_y1} !== seg(80)) begin
      errors++; $display("FAIL zero_next_seg: start=%0b coords=%h want 1 %h", drw_start, {drw_x0, drw_y0, drw_x1, drw_y1}, seg(80)); end
    wait_idle(200);
    checks++; if (lines_done !== 16'd2 || rises !== 1) begin errors++; $display("FAIL zero_next_done: lines_done=%0d rises=%0d want 2 1", lines_done, rises); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    dm_en = 1'b0;
    push(seg(70));
    tick(); tick();
    checks++; if (drw_start !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_armed: start=%0b timeout_err=%0b want 1 0", drw_start, timeout_err); end
    wait_start_fall(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL to_window: got %0d cycles want 16", n); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %0b want 1", timeout_err); end
    tick(); tick();
    checks++; if (lines_done !== 16'd1) begin errors++; $display("FAIL to_dropped: got %0d want 1", lines_done); end
    dm_en = 1'b1; dm_delay = 2; dm_len = 3;
    push(seg(71));
    wait_idle(200);
    checks++; if (lines_done !== 16'd2 || rises !== 2) begin errors++; $display("FAIL to_next: lines_done=%0d rises=%0d want 2 2", lines_done, rises); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %0b want 1", timeout_err); end
  endtask

  task automatic test_back_to_back();
    int acc;
    do_reset();
    dm_en = 1'b0; dm_hold = 1'b1;
    push(seg(0));
    repeat (3) tick();
    for (int i = 1; i <= 16; i++) push(seg(i));
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL b2b_full_level: got %0d want 16", fifo_level); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0b want 0", cmd_ready); end
    {cmd_x0, cmd_y0, cmd_x1, cmd_y1} = seg(17);
    cmd_valid = 1'b1;
    acc = 0;
    repeat (5) begin tick(); if (cmd_ready) acc++; end
    checks++; if (acc !== 0 || fifo_level !== 5'd16) begin errors++; $display("FAIL b2b_blocked: ready_seen=%0d level=%0d want 0 16", acc, fifo_level); end
    dm_hold = 1'b0; dm_en = 1'b1; dm_delay = 1; dm_len = 2;
    push(seg(17));
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL b2b_refill: got %0d want 16", fifo_level); end
    wait_idle(3000);
    checks++; if (idle !== 1'b1 || lines_done !== 16'd18) begin errors++; $display("FAIL b2b_drain: idle=%0b lines_done=%0d want 1 18", idle, lines_done); end
    checks++; if (rises !== 18) begin errors++; $display("FAIL b2b_starts: got %0d want 18", rises); end
    checks++; if (gap_viol !== 0) begin errors++; $display("FAIL b2b_low_gap: got %0d short gaps want 0", gap_viol); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL b2b_coord_stable: got %0d changes want 0", stab_viol); end
    for (int i = 0; i < 18 && i < rec.size(); i++) begin
      checks++;
      if (rec[i] !== seg(i)) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, rec[i], seg(i)); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    dm_en = 1'b0; dm_hold = 1'b1;
    push({16'd7, 16'd8, 16'd9, 16'd10});
    repeat (3) tick();
    for (int i = 0; i < 5; i++) push(seg(40 + i));
    checks++; if (fifo_level !== 5'd5) begin errors++; $display("FAIL flush_pre_level: got %0d want 5", fifo_level); end
    {cmd_x0, cmd_y0, cmd_x1, cmd_y1} = seg(99);
    flush = 1'b1; cmd_valid = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b want 0", cmd_ready); end
    @(posedge clk); #1;
    flush = 1'b0; cmd_valid = 1'b0;
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL flush_level: got %0d want 0", fifo_level); end
    tick();
    checks++; if (fifo_level !== 5'd0 || drw_start !== 1'b1) begin errors++; $display("FAIL flush_inflight: level=%0d start=%0b want 0 1", fifo_level, drw_start); end
    dm_hold = 1'b0;
    wait_idle(100);
    checks++; if (lines_done !== 16'd1 || idle !== 1'b1) begin errors++; $display("FAIL flush_finish: lines_done=%0d idle=%0b want 1 1", lines_done, idle); end
    checks++; if (rises !== 1 || drw_x0 !== 16'd7) begin errors++; $display("FAIL flush_only_one: rises=%0d x0=%0d want 1 7", rises, drw_x0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dm_en = 1'b1; dm_delay = 2; dm_len = 50;
    push({16'd5, 16'd5, 16'd5, 16'd5});
    tick(); tick();
    push(seg(60));
    push(seg(61));
    repeat (6) tick();
    checks++; if (drw_start !== 1'b1 || lines_done !== 16'd1) begin errors++; $display("FAIL rstmid_pre: start=%0b lines_done=%0d want 1 1", drw_start, lines_done); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (drw_start !== 1'b0) begin errors++; $display("FAIL rstmid_start: got %0b want 0", drw_start); end
    checks++; if (fifo_level !== 5'd0 || lines_done !== 16'd0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_counters: level=%0d lines_done=%0d timeout_err=%0b want 0 0 0", fifo_level, lines_done, timeout_err); end
    checks++; if (idle !== 1'b1 || drw_x0 !== 16'd0) begin errors++; $display("FAIL rstmid_state: idle=%0b x0=%0d want 1 0", idle, drw_x0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1 || idle !== 1'b1 || drw_start !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: ready=%0b idle=%0b start=%0b want 1 1 0", cmd_ready, idle, drw_start); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_length();
    test_timeout();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
